// File: rtl/tmvp_pkg.sv
// tmvp_pkg: definitions shared by the TMVP datapath stages.
//   tmvp_state_e : row accumulator FSM states
//   acc_width()  : product/accumulator width derived from the operand width
package tmvp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } tmvp_state_e;

    // The multiplier yields a double-width product; downstream sums keep that width.
    function automatic int unsigned acc_width(input int unsigned int_size);
        return 2 * int_size;
    endfunction

endpackage

// File: rtl/tmvp_row_accum_if.sv
// tmvp_row_accum_if: product stream in, row results out, for the row accumulator.
//   slave  : accumulator side (consumes products, produces rows)
//   master : producer/consumer side
import tmvp_pkg::*;

interface tmvp_row_accum_if #(
    parameter int unsigned INT_SIZE = 16
) ();
    localparam int unsigned AW = acc_width(INT_SIZE);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] prod;
    logic          prod_neg;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] row_sum;
    logic [INT_SIZE-1:0] row_coef;
    logic          wrapped;
    logic          busy;

    modport slave (
        input  in_valid, prod, prod_neg, flush, out_ready,
        output in_ready, out_valid, row_sum, row_coef, wrapped, busy
    );

    modport master (
        output in_valid, prod, prod_neg, flush, out_ready,
        input  in_ready, out_valid, row_sum, row_coef, wrapped, busy
    );
endinterface

// File: rtl/tmvp_out_buf.sv
// tmvp_out_buf: one-entry valid/ready holding register for a result word plus flag.
//   clk, rst  : clock, synchronous active-low reset
//   i_load    : capture i_data/i_wrap and raise o_valid
//   i_ready   : downstream accepts when o_valid & i_ready
//   o_valid   : entry occupied
//   o_data    : held result (retained after drain)
//   o_wrap    : held flag
module tmvp_out_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_wrap,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_wrap
);

    // A load on the same edge as a drain wins, so the entry stays valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_wrap  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_wrap  <= i_wrap;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tmvp_row_accum.sv
// tmvp_row_accum: accumulates ROW_LEN signed-contribution products mod 2^(2*INT_SIZE)
// into one row result, handed off through a one-entry valid/ready buffer.
//   clk, rst  : clock, synchronous active-low reset
//   bus.slave : in_valid/in_ready/prod/prod_neg/flush in;
//               out_valid/out_ready/row_sum/row_coef/wrapped/busy out
import tmvp_pkg::*;

module tmvp_row_accum #(
    parameter int unsigned INT_SIZE = 16,
    parameter int unsigned ROW_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    tmvp_row_accum_if.slave  bus
);

    localparam int unsigned AW    = acc_width(INT_SIZE);
    localparam int unsigned CNT_W = $clog2(ROW_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

    tmvp_state_e      r_state;
    tmvp_state_e      w_state_next;
    logic [AW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_row_done;
    logic [AW:0]      w_sum_ext;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_out_valid;
    logic             w_ov_next;
    logic [AW-1:0]    w_row_sum;
    logic             w_row_wrap;

    assign w_last     = (r_cnt == LAST);
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
    assign w_row_done = w_accept && w_last;

    // Extra top bit is the carry (add) or borrow (subtract) out of AW bits.
    always_comb begin
        w_sum_ext = '0;
        if (bus.prod_neg) begin
            w_sum_ext = {1'b0, r_acc} - {1'b0, bus.prod};
        end else begin
            w_sum_ext = {1'b0, r_acc} + {1'b0, bus.prod};
        end
    end

    assign w_cnt_next = (w_accept && !w_last) ? r_cnt + CNT_W'(1) : r_cnt;
    // Buffer occupancy after this edge; lets the FSM enter STALL in step with in_ready.
    assign w_ov_next  = w_row_done || (w_out_valid && !bus.out_ready);

    // Accumulator, beat counter and row-local wrap bit.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush || w_row_done) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_sum_ext[AW-1:0];
            r_cnt  <= w_cnt_next;
            r_wrap <= r_wrap | w_sum_ext[AW];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_cnt_next == LAST && w_ov_next) ? STALL : ACCUM;
                end
            end
            ACCUM, STALL: begin
                if (w_row_done) begin
                    w_state_next = IDLE;
                end else if (w_cnt_next == LAST && w_ov_next) begin
                    w_state_next = STALL;
                end else begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = IDLE;
        end
    end

    // FSM / datapath outputs; in_ready uses registered terms only.
    always_comb begin
        w_in_ready    = !(w_last && w_out_valid);
        bus.in_ready  = w_in_ready;
        bus.busy      = (r_state == ACCUM);
        bus.out_valid = w_out_valid;
        bus.row_sum   = w_row_sum;
        bus.row_coef  = w_row_sum[INT_SIZE-1:0];
        bus.wrapped   = w_row_wrap;
    end

    tmvp_out_buf #(
        .W (AW)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_row_done),
        .i_data  (w_sum_ext[AW-1:0]),
        .i_wrap  (r_wrap | w_sum_ext[AW]),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_row_sum),
        .o_wrap  (w_row_wrap)
    );

endmodule

// File: tb/tb_tmvp_row_accum.sv
// tb_tmvp_row_accum: directed vectors with hand-computed expectations for tmvp_row_accum
// (INT_SIZE=16, ROW_LEN=4).
module tb_tmvp_row_accum;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    tmvp_row_accum_if #(.INT_SIZE(16)) bus ();

    tmvp_row_accum #(
        .INT_SIZE (16),
        .ROW_LEN  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one cycle; it must be accepted.
    task automatic beat(input logic [31:0] p, input logic n);
        bus.in_valid = 1'b1;
        bus.prod     = p;
        bus.prod_neg = n;
        chk("in_ready_at_beat", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.prod     = '0;
        bus.prod_neg = 1'b0;
    endtask

    task automatic chk_row(input string tag, input logic [31:0] sum, input logic wrap);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_sum"},   64'(bus.row_sum),   64'(sum));
        chk({tag, "_coef"},  64'(bus.row_coef),  64'(sum[15:0]));
        chk({tag, "_wrap"},  64'(bus.wrapped),   64'(wrap));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_row_sum"},   64'(bus.row_sum),   64'd0);
        chk({tag, "_row_coef"},  64'(bus.row_coef),  64'd0);
        chk({tag, "_wrapped"},   64'(bus.wrapped),   64'd0);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.prod_neg  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset and idle.
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b1;
        tick();
        chk_reset("idle");

        // Row 10+20+30+40 with out_ready held high.
        beat(32'd10, 1'b0);
        chk("r1_busy", 64'(bus.busy), 64'd1);
        beat(32'd20, 1'b0);
        beat(32'd30, 1'b0);
        beat(32'd40, 1'b0);
        chk_row("r1", 32'd100, 1'b0);
        chk("r1_busy_done", 64'(bus.busy), 64'd0);

        // Next row follows with no bubble: 5 - 7 + 1 + 0 wraps to all ones.
        beat(32'd5, 1'b0);
        chk("r2_drained", 64'(bus.out_valid), 64'd0);
        beat(32'd7, 1'b1);
        beat(32'd1, 1'b0);
        beat(32'd0, 1'b0);
        chk_row("r2", 32'hFFFF_FFFF, 1'b1);

        // Wrap bit is row-local: 1+1+1+1.
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        chk_row("r3", 32'd4, 1'b0);

        // Carry out of 32 bits on an add: 0xFFFFFFFF + 2 + 0 + 0 = 1.
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd0, 1'b0);
        beat(32'd0, 1'b0);
        chk_row("r4", 32'd1, 1'b1);
        tick();
        chk("r4_drained", 64'(bus.out_valid), 64'd0);

        // Back-pressure: row A held, row B stalls on its last beat.
        bus.out_ready = 1'b0;
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        chk_row("rA", 32'd4, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b0);
        bus.in_valid = 1'b1;
        bus.prod     = 32'd1;
        chk("rB_stall_ready", 64'(bus.in_ready), 64'd0);
        chk("rB_stall_busy",  64'(bus.busy),     64'd0);
        tick();
        chk("rB_stall_ready2", 64'(bus.in_ready),  64'd0);
        chk("rB_stall_valid",  64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("rB_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("rB_drain_ready", 64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.prod     = '0;
        chk_row("rB", 32'd4, 1'b0);

        // Flush drops a partial row and the beat presented with it; buffer kept.
        beat(32'd100, 1'b0);
        beat(32'd100, 1'b0);
        bus.in_valid = 1'b1;
        bus.prod     = 32'd100;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.prod     = '0;
        bus.flush    = 1'b0;
        chk("fl_busy", 64'(bus.busy), 64'd0);
        chk_row("fl_keep", 32'd4, 1'b0);
        bus.out_ready = 1'b1;
        beat(32'd1, 1'b0);
        chk("fl_drained", 64'(bus.out_valid), 64'd0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b0);
        chk_row("fl_row", 32'd10, 1'b0);

        // Reset mid-row with the buffer full loses everything.
        bus.out_ready = 1'b0;
        beat(32'd9, 1'b0);
        beat(32'd9, 1'b0);
        chk("mr_busy",  64'(bus.busy),      64'd1);
        chk("mr_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b0;
        tick();
        chk_reset("mr");
        rst = 1'b1;
        bus.out_ready = 1'b1;
        beat(32'd7, 1'b0);
        beat(32'd7, 1'b0);
        beat(32'd7, 1'b0);
        beat(32'd7, 1'b0);
        chk_row("post_rst", 32'd28, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tmvp_row_accum.md
# tmvp_row_accum

Downstream consumer of the 2·INT_SIZE-bit product multiplier in the TMVP datapath. Accepts a stream of signed-contribution products (add or subtract, as required for negacyclic Toeplitz rows) and accumulates ROW_LEN of them modulo 2^(2·INT_SIZE) into one row result. Each completed row is presented on a one-entry output buffer with a valid/ready handshake, so the next row can accumulate while the previous one drains. Also provides a sticky wrap flag and flush.

## Interface
- INT_SIZE, 16, operand width of the upstream multiplier; products and accumulator are 2·INT_SIZE bits
- ROW_LEN, 4, products per row (≥2)
- CNT_W, $clog2(ROW_LEN), beat counter width (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  product beat valid (driven from multiplier done/result)
- in_ready  output  1  beat accepted when in_valid & in_ready
- prod  input  2·INT_SIZE  unsigned product from multiplier
- prod_neg  input  1  1 = subtract prod, 0 = add
- flush  input  1  discard partial row, return to IDLE
- out_valid  output  1  row result held in output buffer
- out_ready  input  1  consumer takes result when out_valid & out_ready
- row_sum  output  2·INT_SIZE  accumulated row, mod 2^(2·INT_SIZE)
- row_coef  output  INT_SIZE  row_sum[low INT_SIZE bits], ring coefficient mod 2^INT_SIZE
- wrapped  output  1  sticky: any carry/borrow out of 2·INT_SIZE during the row now in buffer
- busy  output  1  state == ACCUM

## Operation
- States: IDLE (cnt=0, acc=0), ACCUM (cnt>0), STALL (last beat pending, output buffer occupied).
- IDLE→ACCUM on accepted beat; ACCUM→IDLE when accepted beat has cnt==ROW_LEN-1 (row completes); ACCUM→STALL when cnt==ROW_LEN-1 and out_valid=1; STALL→ACCUM when buffer drains.
- Beat accepted: acc_next = acc ± prod (mod 2^(2·INT_SIZE)); carry (add) or borrow (sub) sets row-local wrap bit; cnt increments.
- Row complete (last beat accepted): row_sum ← acc_next, wrapped ← row wrap bit | this beat's carry/borrow, out_valid ← 1; acc, cnt, row wrap bit cleared same edge.
- in_ready = !(cnt==ROW_LEN-1 && out_valid); registered terms only, no comb path from out_ready.
- Output buffer: out_valid clears on out_valid & out_ready unless a new row completes same edge (then reloads, stays 1).
- flush: acc, cnt, row wrap bit cleared, state → IDLE; beat presented same cycle is dropped (flush wins). Output buffer unaffected.
- ROW_LEN beats are the only row delimiter; no explicit last signal.

## Timing
- Reset: in_ready=1, out_valid=0, row_sum=0, row_coef=0, wrapped=0, busy=0, acc=0, cnt=0, state IDLE.
- Throughput: one beat per cycle while in_ready=1.
- Latency: row_sum/out_valid visible the cycle after the last beat's accepting edge.
- Back-to-back rows with out_ready=1 held: no bubbles.
- Buffer full and last beat of next row arriving: in_ready=0 until the cycle after out_ready handshake; one-cycle bubble minimum.
- Reset mid-row or with buffer full: everything cleared, pending result lost.
- row_coef is combinational slice of row_sum register.

## Structure
- tmvp_pkg: state enum (IDLE, ACCUM, STALL), accumulator-width constant/function of INT_SIZE, shared with multiplier and other TMVP stages.
- One sub-module: tmvp_out_buf, a one-entry valid/ready holding register (row_sum, wrapped), reusable by other TMVP stages.
- Accumulator, counter, FSM stay in the top module.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, row_sum=0, wrapped=0, busy=0.
- INT_SIZE=16, ROW_LEN=4, out_ready=1: add 10,20,30,40 on consecutive cycles → next cycle out_valid=1, row_sum=100, row_coef=100, wrapped=0; second row immediately follows with no bubble.
- Add 5, sub 7, add 1, add 0 → row_sum=0xFFFFFFFF, row_coef=0xFFFF, wrapped=1; next row 1,1,1,1 → row_sum=4, wrapped=0.
- out_ready=0: complete row A (sum 4), stream row B of 1s: in_ready drops on B's 4th beat; raise out_ready → A taken, B's last beat accepted one cycle later, row_sum=4 for B.
- Two beats of 100, flush with third beat valid, then 1,2,3,4 → row_sum=10; buffered prior result unchanged by flush.
- rst low during ACCUM with out_valid=1 → all outputs at reset values next cycle; following row of 7,7,7,7 yields 28.
